lsu_mem_stage: RTL and testbench

Load/store unit sitting directly upstream of the word-addressed data memory (64 x 32-bit, combinational read, synchronous write on clk, async reset reload). It accepts byte/halfword/word load and store requests from the execute stage using RISC-V funct3 encoding. It converts byte addresses to word indices and performs read-modify-write for sub-word stores. Loads return sign- or zero-extended data; misaligned, out-of-range and illegal accesses are flagged without touching memory.

---
 rtl/lsu_mem_stage_if.sv | 34 +++
 rtl/lsu_mem_stage.sv | 187 ++++++++++++++++++
 tb/tb_lsu_mem_stage.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_stage_if.sv
// Request/response and data-memory bus of the load/store unit.
// The slave modport is the LSU itself. The master modport is its environment,
// which is the execute stage on the request side and the data memory on the
// memory side. It therefore drives mem_rdata.
interface lsu_mem_stage_if #(
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [2:0]        req_funct3;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_err;
   logic              mem_re;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
             mem_re, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
             mem_re, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/lsu_mem_stage.sv
// Load/store unit in front of a word-addressed 32-bit data memory.
// It handles byte, halfword and word loads and stores, using RISC-V funct3 codes.
// Sub-word stores are done as a read-modify-write.
// Misaligned, out-of-range and illegal requests return an error and never touch memory.
module lsu_mem_stage #(
   parameter int MEM_DEPTH = 64,
   parameter int ADDR_W    = 32
) (
   input logic            clk,
   input logic            reset,
   lsu_mem_stage_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD      = 3'd1,
      WRITE     = 3'd2,
      RMW_READ  = 3'd3,
      RMW_WRITE = 3'd4,
      RESP      = 3'd5
   } state_t;

   localparam logic [ADDR_W-3:0] DEPTH_W = (ADDR_W-2)'(MEM_DEPTH);

   state_t            state_q, state_d;
   logic              we_q;
   logic [2:0]        funct3_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       merge_q;
   logic [31:0]       resp_rdata_q;
   logic              resp_err_q;

   logic              acc_err;
   logic              ready;
   logic              rd_en;
   logic              wr_en;
   logic              rsp;
   logic [ADDR_W-1:0] word_addr;
   logic [31:0]       wr_word;

   // A request is rejected if funct3 is illegal for its direction, if it is
   // misaligned for its access size, or if its word index falls past the memory.
   function automatic logic req_error(input logic we, input logic [2:0] f3,
                                      input logic [ADDR_W-1:0] addr);
      logic illegal;
      logic misal;
      logic oor;
      if (we) illegal = (f3 > 3'd2);
      else    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      misal = ((f3[1:0] == 2'd1) && addr[0]) ||
              ((f3[1:0] == 2'd2) && (addr[1:0] != 2'd0));
      oor   = (addr[ADDR_W-1:2] >= DEPTH_W);
      return illegal | misal | oor;
   endfunction

   // Select the addressed byte or halfword lane, then sign- or zero-extend it.
   // A word load passes the word through unchanged.
   function automatic logic [31:0] load_extend(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  lane);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic signed [31:0] r;
      b = word[{lane, 3'b000} +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      case (f3)
         3'd0:    r = b;
         3'd1:    r = h;
         3'd4:    r = {24'd0, b};
         3'd5:    r = {16'd0, h};
         default: r = word;
      endcase
      return r;
   endfunction

   // Replace the addressed byte or halfword of the read-back word with store data.
   function automatic logic [31:0] store_merge(input logic [31:0] word,
                                               input logic [15:0] wd,
                                               input logic        half,
                                               input logic [1:0]  lane);
      logic [31:0] r;
      r = word;
      if (half) begin
         if (lane[1]) r[31:16] = wd;
         else         r[15:0]  = wd;
      end else begin
         r[{lane, 3'b000} +: 8] = wd[7:0];
      end
      return r;
   endfunction

   // State register. An async reset aborts any access in flight, and because the
   // memory strobes decode from this register they drop at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next state and memory/handshake strobes. The strobes are decoded from the
   // current state only.
   always_comb begin
      state_d   = state_q;
      ready     = 1'b0;
      rd_en     = 1'b0;
      wr_en     = 1'b0;
      rsp       = 1'b0;
      word_addr = '0;
      wr_word   = '0;
      acc_err   = req_error(bus.req_we, bus.req_funct3, bus.req_addr);
      case (state_q)
         IDLE: begin
            ready = 1'b1;
            if (bus.req_valid) begin
               if (acc_err)                     state_d = RESP;
               else if (!bus.req_we)            state_d = LOAD;
               else if (bus.req_funct3 == 3'd2) state_d = WRITE;
               else                             state_d = RMW_READ;
            end
         end
         LOAD: begin
            rd_en     = 1'b1;
            word_addr = {2'b00, addr_q[ADDR_W-1:2]};
            state_d   = RESP;
         end
         WRITE: begin
            wr_en     = 1'b1;
            word_addr = {2'b00, addr_q[ADDR_W-1:2]};
            wr_word   = wdata_q;
            state_d   = RESP;
         end
         RMW_READ: begin
            rd_en     = 1'b1;
            word_addr = {2'b00, addr_q[ADDR_W-1:2]};
            state_d   = RMW_WRITE;
         end
         RMW_WRITE: begin
            wr_en     = 1'b1;
            word_addr = {2'b00, addr_q[ADDR_W-1:2]};
            wr_word   = store_merge(merge_q, wdata_q[15:0], funct3_q[0], addr_q[1:0]);
            state_d   = RESP;
         end
         RESP: begin
            rsp     = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Capture the request, the read-back word used by the merge, and the response.
   // The response registers change only on entry to RESP, so they hold between pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         we_q         <= 1'b0;
         funct3_q     <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         merge_q      <= '0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         if (state_q == IDLE && bus.req_valid) begin
            we_q     <= bus.req_we;
            funct3_q <= bus.req_funct3;
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
         end
         if (state_q == RMW_READ) merge_q <= bus.mem_rdata;
         if (state_d == RESP) begin
            resp_err_q   <= (state_q == IDLE) ? acc_err : 1'b0;
            resp_rdata_q <= (state_q == LOAD && !we_q)
                            ? load_extend(bus.mem_rdata, funct3_q, addr_q[1:0]) : '0;
         end
      end
   end

   assign bus.req_ready  = ready;
   assign bus.resp_valid = rsp;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.mem_re     = rd_en;
   assign bus.mem_we     = wr_en;
   assign bus.mem_addr   = word_addr;
   assign bus.mem_wdata  = wr_word;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage. It pairs the unit with a 64-word data memory, then
// runs directed and random transactions.
// Each result is checked against a reference model that works on whole words.
module tb_lsu_mem_stage;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   n_vec = 0;
   int   n_mis = 0;

   lsu_mem_stage_if #(.ADDR_W(32)) bus ();

   lsu_mem_stage #(.MEM_DEPTH(64), .ADDR_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reload image of the data memory.
   function automatic logic [31:0] init_word(input int i);
      case (i)
         0:       return 32'd0;
         1:       return 32'd84;
         2:       return 32'd23;
         4:       return 32'd91;
         default: return 32'(i) * 32'h0101_0101;
      endcase
   endfunction

   // Data memory: combinational read, write on clk, reload on async reset.
   logic [31:0] mem [64];
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      end else if (bus.mem_we) begin
         mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
      end
   end
   assign bus.mem_rdata = mem[bus.mem_addr[5:0]];

   logic [31:0] ref_mem [64];

   task automatic ref_reset();
      for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model. It works out the expected outcome of a request from the
   // access rules alone, using shifts and masks on whole words.
   task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic err, output logic [31:0] rd,
                        output int lat, output int nre, output int nwe,
                        output logic [31:0] wword);
      int unsigned     wi;
      int              size;
      bit              legal;
      longint unsigned mask;
      longint unsigned sh;
      longint          v;
      wi = addr >> 2;
      case (f3)
         3'd0, 3'd4: size = 1;
         3'd1, 3'd5: size = 2;
         default:    size = 4;
      endcase
      legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
      err   = !legal || ((addr % size) != 0) || (wi >= 64);
      rd = 32'd0; lat = 1; nre = 0; nwe = 0; wword = 32'd0;
      if (err) return;
      mask = (64'd1 << (8 * size)) - 1;
      sh   = 64'(8 * int'(addr[1:0]));
      if (!we) begin
         v = longint'((64'(ref_mem[wi]) >> sh) & mask);
         if (f3 < 3'd4 && size < 4 && v >= longint'((mask + 1) / 2)) v = v - longint'(mask + 1);
         rd  = v[31:0];
         lat = 2;
         nre = 1;
      end else begin
         if (size == 4) begin
            wword = wd;
            lat   = 2;
            nwe   = 1;
         end else begin
            wword = 32'((64'(ref_mem[wi]) & ~(mask << sh)) | ((64'(wd) & mask) << sh));
            lat   = 3;
            nre   = 1;
            nwe   = 1;
         end
         ref_mem[wi] = wword;
      end
   endtask

   // Issue one request starting at a falling edge, then follow it until its
   // response pulse is over. Returns at a falling edge with the unit idle.
   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input string tag, output logic [31:0] got);
      logic        e_err;
      logic [31:0] e_rd;
      logic [31:0] e_word;
      int          e_lat, e_re, e_we;
      int          guard, lat, re_c, we_c;
      logic        both, rdy_hi;
      logic [31:0] a_seen, wd_seen;
      model(we, f3, addr, wd, e_err, e_rd, e_lat, e_re, e_we, e_word);
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wd;
      guard = 0;
      while (bus.req_ready !== 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 20) chk({tag, "_ready_timeout"}, 32'(guard), 32'd0);
      @(posedge clk);
      lat = 0; re_c = 0; we_c = 0; both = 1'b0; rdy_hi = 1'b0;
      a_seen = 32'hFFFF_FFFF; wd_seen = 32'hFFFF_FFFF;
      do begin
         @(negedge clk);
         if (lat == 0) bus.req_valid = 1'b0;
         lat++;
         re_c += int'(bus.mem_re);
         we_c += int'(bus.mem_we);
         if (bus.mem_re && bus.mem_we) both = 1'b1;
         if (bus.req_ready) rdy_hi = 1'b1;
         if (bus.mem_re || bus.mem_we) a_seen = bus.mem_addr;
         if (bus.mem_we) wd_seen = bus.mem_wdata;
      end while (bus.resp_valid !== 1'b1 && lat < 10);
      got = bus.resp_rdata;
      chk({tag, "_latency"}, 32'(lat), 32'(e_lat));
      chk({tag, "_err"}, 32'(bus.resp_err), 32'(e_err));
      chk({tag, "_rdata"}, bus.resp_rdata, e_rd);
      chk({tag, "_re_cycles"}, 32'(re_c), 32'(e_re));
      chk({tag, "_we_cycles"}, 32'(we_c), 32'(e_we));
      chk({tag, "_re_we_overlap"}, 32'(both), 32'd0);
      chk({tag, "_ready_busy"}, 32'(rdy_hi), 32'd0);
      if (e_re != 0 || e_we != 0) chk({tag, "_mem_addr"}, a_seen, addr >> 2);
      if (e_we != 0) chk({tag, "_mem_wdata"}, wd_seen, e_word);
      @(negedge clk);
      chk({tag, "_pulse_end"}, 32'(bus.resp_valid), 32'd0);
      chk({tag, "_rdata_hold"}, bus.resp_rdata, e_rd);
      chk({tag, "_idle_wdata"}, bus.mem_wdata, 32'd0);
   endtask

   initial begin : stim
      logic [31:0] got;
      logic        m_err;
      logic [31:0] m_rd, m_rd2, m_word;
      int          m_lat, m_re, m_we;
      int          n_resp, n_acc, first_rdy, wecnt, rv_cnt;
      logic [31:0] last_rd;
      logic        r_we;
      logic [2:0]  r_f3;
      logic [31:0] r_addr;

      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_funct3 = 3'd0;
      bus.req_addr   = 32'd0;
      bus.req_wdata  = 32'd0;

      // Reset state
      #3 reset = 1'b1;
      ref_reset();
      @(negedge clk);
      @(negedge clk);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
      chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
      chk("rst_mem_re", 32'(bus.mem_re), 32'd0);
      chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'd0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
      reset = 1'b0;

      // Word load from the reload image
      do_req(1'b0, 3'd2, 32'h4, 32'h0, "lw4", got);
      chk("lw4_const", got, 32'h0000_0054);

      // Byte store through read-modify-write, then read back
      do_req(1'b1, 3'd0, 32'h5, 32'h1234_56AB, "sb5", got);
      do_req(1'b0, 3'd0, 32'h5, 32'h0, "lb5", got);
      chk("lb5_const", got, 32'hFFFF_FFAB);
      do_req(1'b0, 3'd4, 32'h5, 32'h0, "lbu5", got);
      chk("lbu5_const", got, 32'h0000_00AB);
      do_req(1'b0, 3'd2, 32'h4, 32'h0, "lw4b", got);
      chk("lw4b_const", got, 32'h0000_AB54);

      // Upper-half store, then signed and unsigned halfword loads
      do_req(1'b1, 3'd1, 32'h12, 32'h0000_BEEF, "sh12", got);
      do_req(1'b0, 3'd1, 32'h12, 32'h0, "lh12", got);
      chk("lh12_const", got, 32'hFFFF_BEEF);
      do_req(1'b0, 3'd5, 32'h12, 32'h0, "lhu12", got);
      chk("lhu12_const", got, 32'h0000_BEEF);
      do_req(1'b0, 3'd2, 32'h10, 32'h0, "lw16", got);
      chk("lw16_const", got, 32'hBEEF_005B);

      // Error cases
      do_req(1'b1, 3'd1, 32'h3,   32'hFFFF_FFFF, "err_sh3", got);
      do_req(1'b0, 3'd2, 32'h102, 32'h0, "err_lw102", got);
      do_req(1'b0, 3'd2, 32'h100, 32'h0, "err_lw100", got);
      do_req(1'b0, 3'd3, 32'h0,   32'h0, "err_f3", got);
      chk("err_f3_flag", 32'(bus.resp_err), 32'd1);
      do_req(1'b0, 3'd2, 32'h0,   32'h0, "lw0", got);
      chk("lw0_const", got, 32'd0);

      // Back-to-back requests with req_valid held high
      model(1'b1, 3'd2, 32'h20, 32'hCAFE_F00D, m_err, m_rd, m_lat, m_re, m_we, m_word);
      model(1'b0, 3'd2, 32'h20, 32'h0, m_err, m_rd2, m_lat, m_re, m_we, m_word);
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b1;
      bus.req_funct3 = 3'd2;
      bus.req_addr   = 32'h20;
      bus.req_wdata  = 32'hCAFE_F00D;
      @(posedge clk);
      #1;
      bus.req_we    = 1'b0;
      bus.req_wdata = 32'h0;
      n_resp = 0; n_acc = 1; first_rdy = -1; wecnt = 0; last_rd = 32'h0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.resp_valid) begin
            n_resp++;
            last_rd = bus.resp_rdata;
         end
         wecnt += int'(bus.mem_we);
         if (bus.req_valid && bus.req_ready) begin
            if (first_rdy < 0) first_rdy = i;
            @(posedge clk);
            n_acc++;
            #1 bus.req_valid = 1'b0;
         end
      end
      chk("bp_first_ready", 32'(first_rdy), 32'd2);
      chk("bp_accepts", 32'(n_acc), 32'd2);
      chk("bp_responses", 32'(n_resp), 32'd2);
      chk("bp_load_data", last_rd, m_rd2);
      chk("bp_write_cycles", 32'(wecnt), 32'd1);

      // Random traffic
      for (int n = 0; n < 200; n++) begin
         r_we = 1'($urandom_range(0, 1));
         r_f3 = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 9))
            0:       r_addr = 32'h100 + 32'($urandom_range(0, 255));
            1:       r_addr = $urandom;
            default: r_addr = 32'($urandom_range(0, 255));
         endcase
         do_req(r_we, r_f3, r_addr, $urandom, "rnd", got);
      end

      // Reset while the merged word is being written
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b1;
      bus.req_funct3 = 3'd0;
      bus.req_addr   = 32'h8;
      bus.req_wdata  = 32'h0000_0077;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      chk("rst_mid_we_before", 32'(bus.mem_we), 32'd1);
      reset = 1'b1;
      #1;
      chk("rst_mid_we_drop", 32'(bus.mem_we), 32'd0);
      ref_reset();
      rv_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         rv_cnt += int'(bus.resp_valid);
      end
      reset = 1'b0;
      chk("rst_mid_no_resp", 32'(rv_cnt), 32'd0);
      chk("rst_mid_ready", 32'(bus.req_ready), 32'd1);
      do_req(1'b0, 3'd2, 32'h8, 32'h0, "lw8", got);
      chk("lw8_const", got, 32'd23);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
